ecc_scrub_ctrl: RTL and testbench
=================================

# ecc_scrub_ctrl

Controller that sits between a host port and a single-port ECC-protected memory and owns all access to it. It encodes host writes with `ecc_enc` and decodes every read with `ecc_dec`, both using K=`K` and P0_LSB=1. When idle, it runs a background scrubber that walks the memory, rewrites single-bit-corrupted words, and logs double-bit errors. The host always has priority; scrub operations run only in otherwise idle cycles.

## Interface
- `K`, 32: information word width.
- `AW`, 10: address width; memory depth is 2**AW words.
- `SCRUB_INTERVAL`, 1024: cycles between scrub operations; must be ≥2.
- Derived: `m` = smallest value with 2**m ≥ m+K+1; `N` = m+K+1, the stored codeword width (39 for K=32).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `host_req_i` in 1: host access request.
- `host_we_i` in 1: 1 = write, 0 = read.
- `host_addr_i` in AW: host address.
- `host_d_i` in K: host write data.
- `host_gnt_o` out 1: request accepted this cycle (combinational).
- `host_rvalid_o` out 1: read data valid, one-cycle pulse.
- `host_q_o` out K: corrected read data.
- `host_sberr_o` / `host_dberr_o` out 1 each: error flags qualified by `host_rvalid_o`.
- `mem_req_o`, `mem_we_o` out 1 each: memory strobe and write enable.
- `mem_addr_o` out AW: memory address.
- `mem_d_o` out N: codeword to memory.
- `mem_q_i` in N: read codeword, valid exactly 1 cycle after a read strobe.
- `scrub_en_i` in 1: enable background scrubbing.
- `cnt_clr_i` in 1: clear error counters.
- `scrub_busy_o` out 1: scrub sequence in progress.
- `sb_cnt_o`, `db_cnt_o` out 16 each: saturating counts of corrected and uncorrectable scrub errors.
- `db_err_o` out 1: one-cycle pulse on an uncorrectable scrub error.
- `db_addr_o` out AW: address of the last uncorrectable scrub error.

## Operation
- FSM states: IDLE, HRD (host read data return), SRD (scrub read data return), SWB (scrub write-back).
- **IDLE with `host_req_i`:**
  - `host_gnt_o`=1, `mem_req_o`=1, `mem_addr_o`=`host_addr_i`.
  - Write: `mem_we_o`=1, `mem_d_o`=enc(`host_d_i`); stay in IDLE.
  - Read: go to HRD.
- **HRD:** decode `mem_q_i` and register data/flags; go to IDLE. A single-bit host-read error is corrected for the host but NOT written back; the scrubber repairs it later.
- **IDLE, no host request, `scrub_pend`=1:** issue a read at `scrub_addr`; go to SRD.
- **SRD**, decode `mem_q_i`:
  - Single error: latch the corrected data, increment `sb_cnt`, go to SWB.
  - Double error: increment `db_cnt`, latch `db_addr_o`=`scrub_addr`, pulse `db_err_o`, go to IDLE. No write-back.
  - Clean: go to IDLE.
  - In every case, clear `scrub_pend` and advance `scrub_addr` (2**AW−1 wraps to 0).
- **SWB:** `mem_req_o`=`mem_we_o`=1, `mem_addr_o`=latched scrub address, `mem_d_o`=enc(corrected data); go to IDLE.
- `host_gnt_o`=0 in HRD, SRD and SWB. The host therefore cannot modify a word between its scrub read and write-back.
- **Scrub timer:**
  - While `scrub_en_i`=1, it counts 0..SCRUB_INTERVAL−1; on reaching SCRUB_INTERVAL−1 it sets `scrub_pend` and wraps to 0.
  - While `scrub_en_i`=0, the timer is held at 0 and `scrub_pend` is cleared.
  - Deasserting `scrub_en_i` mid-sequence does not abort SRD/SWB.
- A pending scrub waits indefinitely while the host keeps requesting; timer ticks during that wait are absorbed (no queuing beyond one pending).
- **Counters:** saturate at 16'hFFFF. `cnt_clr_i` forces both to 0 and wins over a simultaneous increment.
- `scrub_busy_o`=1 in SRD and SWB.
- **Reset** (`rst_ni`=0 at a clock edge):
  - State returns to IDLE; timer, `scrub_addr` and `scrub_pend` clear.
  - `host_rvalid_o`, `host_q_o`, error flags, counters, `db_err_o` and `db_addr_o` all go to 0.
  - Memory strobes are 0 during reset; an in-flight read or write-back is dropped.

## Timing
- **Host write:** granted and written in the same cycle T. Back-to-back writes are possible every cycle.
- **Host read:** granted at T, data decoded at T+1, `host_rvalid_o`/`host_q_o`/flags registered and valid at T+2 for one cycle. Next grant is possible at T+2, so the peak rate is one read per 2 cycles.
- **Scrub:** read at S; decision at S+1; counters, `db_err_o` and `db_addr_o` update at S+2; write-back at S+2 if needed. Host is blocked for 2 cycles (clean/double error) or 3 cycles (single error).
- **Simultaneous host request and `scrub_pend` in IDLE:** host is granted and the scrub is deferred.

## Test plan
- **Host write then read:** write 0xDEADBEEF to addr 5, then read addr 5 → `host_gnt_o` at T, `host_rvalid_o` at T+2, `host_q_o`=0xDEADBEEF, both flags 0.
- **Scrub single-bit repair:** preload addr 0 with the codeword of 0x12345678 with bit 7 flipped; set `scrub_en_i`=1, SCRUB_INTERVAL=4 → SRD→SWB writes the clean codeword to addr 0, `sb_cnt_o`=1, `scrub_addr` becomes 1.
- **Double error:** flip 2 bits at addr 3, then scrub it → `db_err_o` one-cycle pulse, `db_addr_o`=3, `db_cnt_o`=1, no memory write.
- **Priority:** hold `host_req_i`=1 continuously across the timer expiry → no scrub read is issued; the scrub occurs in the first host-idle cycle and `scrub_busy_o` rises then.
- **Wrap and saturation:** with AW=2, run 5 scrubs → addresses 0,1,2,3,0. Force `sb_cnt` to 16'hFFFF plus one more error → stays 16'hFFFF. Assert `cnt_clr_i` in the same cycle as an increment → 0.
- **Reset mid-scrub:** deassert `rst_ni` during SWB → no write issued; next cycle all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: sole owner of a single-port SECDED memory. Host accesses are
// encoded/decoded on the fly; idle cycles run a background scrubber that
// repairs single-bit errors in place and logs double-bit errors.
// Codeword layout: bit 0 is the overall parity bit, bits 1..N-1 are Hamming
// positions with check bits at the power-of-two positions and data bits
// filling the remaining positions in ascending order.
module ecc_scrub_ctrl #(
  parameter int  K              = 32,
  parameter int  AW             = 10,
  parameter int  SCRUB_INTERVAL = 1024,
  localparam int M = (K <= 1)   ? 2 :
                     (K <= 4)   ? 3 :
                     (K <= 11)  ? 4 :
                     (K <= 26)  ? 5 :
                     (K <= 57)  ? 6 :
                     (K <= 120) ? 7 :
                     (K <= 247) ? 8 : 9,
  localparam int N = M + K + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [K-1:0]  host_d_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [K-1:0]  host_q_o,
  output logic          host_sberr_o,
  output logic          host_dberr_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [N-1:0]  mem_d_o,
  input  logic [N-1:0]  mem_q_i,
  input  logic          scrub_en_i,
  input  logic          cnt_clr_i,
  output logic          scrub_busy_o,
  output logic [15:0]   sb_cnt_o,
  output logic [15:0]   db_cnt_o,
  output logic          db_err_o,
  output logic [AW-1:0] db_addr_o
);

  localparam int            TW         = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, HRD, SRD, SWB} state_e;

  typedef struct packed {
    logic [K-1:0] data;
    logic         sb;
    logic         db;
  } dec_t;

  // Place data bits, then choose check bits so the syndrome of the word is 0.
  function automatic logic [N-1:0] ecc_encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic [M-1:0] syn;
    int           j;
    cw  = '0;
    syn = '0;
    j   = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[j];
        if (d[j]) syn ^= M'(i);
        j++;
      end
    end
    for (int b = 0; b < M; b++) cw[1 << b] = syn[b];
    cw[0] = ^cw;
    return cw;
  endfunction

  // Syndrome locates a single flipped bit; overall parity tells single from double.
  function automatic dec_t ecc_decode(input logic [N-1:0] cw);
    logic [N-1:0] fixed;
    logic [M-1:0] syn;
    logic         par;
    dec_t         r;
    int           j;
    syn   = '0;
    fixed = cw;
    r     = '0;
    j     = 0;
    for (int i = 1; i < N; i++) begin
      if (cw[i]) syn ^= M'(i);
    end
    par = ^cw;
    if (syn != '0) begin
      if (par && (int'(syn) < N)) begin
        fixed[syn] = ~fixed[syn];
        r.sb       = 1'b1;
      end else begin
        r.db = 1'b1;
      end
    end else if (par) begin
      r.sb = 1'b1;  // only the overall parity bit flipped; data is intact
    end
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        r.data[j] = fixed[i];
        j++;
      end
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  dec_t          dec;
  logic [TW-1:0] timer_q;
  logic          scrub_pend_q;
  logic [AW-1:0] scrub_addr_q;
  logic [AW-1:0] wb_addr_q;
  logic [K-1:0]  wb_data_q;
  logic          rvalid_q, sberr_q, dberr_q;
  logic [K-1:0]  host_q_q;
  logic [15:0]   sb_cnt_q, db_cnt_q;
  logic          db_err_q;
  logic [AW-1:0] db_addr_q;

  assign dec = ecc_decode(mem_q_i);

  // State register.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and memory/host strobes; host wins over a pending scrub.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    host_gnt_o = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = host_addr_i;
    unique case (state_q)
      IDLE: begin
        if (host_req_i) begin
          host_gnt_o = 1'b1;
          mem_req_o  = 1'b1;
          mem_we_o   = host_we_i;
          if (!host_we_i) state_d = HRD;
        end else if (scrub_pend_q) begin
          mem_req_o  = 1'b1;
          mem_addr_o = scrub_addr_q;
          state_d    = SRD;
        end
      end
      HRD: state_d = IDLE;
      SRD: state_d = dec.sb ? SWB : IDLE;
      SWB: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = wb_addr_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed while reset is asserted, dropping any write-back.
    if (!rst_ni) begin
      host_gnt_o = 1'b0;
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
    end
  end

  assign mem_d_o      = ecc_encode((state_q == SWB) ? wb_data_q : host_d_i);
  assign scrub_busy_o = (state_q == SRD) || (state_q == SWB);

  // Host read return: decoded data and flags registered for a one-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      host_q_q <= '0;
      sberr_q  <= 1'b0;
      dberr_q  <= 1'b0;
    end else begin
      rvalid_q <= (state_q == HRD);
      if (state_q == HRD) begin
        host_q_q <= dec.data;
        sberr_q  <= dec.sb;
        dberr_q  <= dec.db;
      end
    end
  end

  // Scrub timer; a tick arriving while a scrub completes re-arms the pending flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q      <= '0;
      scrub_pend_q <= 1'b0;
    end else if (!scrub_en_i) begin
      timer_q      <= '0;
      scrub_pend_q <= 1'b0;
    end else begin
      if (state_q == SRD) scrub_pend_q <= 1'b0;
      if (timer_q == TIMER_LAST) begin
        timer_q      <= '0;
        scrub_pend_q <= 1'b1;
      end else begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  // Scrub address walks the whole array and wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)              scrub_addr_q <= '0;
    else if (state_q == SRD)  scrub_addr_q <= scrub_addr_q + AW'(1);
  end

  // Write-back buffer for the corrected word.
  // NOTE: pure datapath, deliberately not reset; it is only read in SWB, after a load.
  always_ff @(posedge clk_i) begin
    if (state_q == SRD) begin
      wb_addr_q <= scrub_addr_q;
      wb_data_q <= dec.data;
    end
  end

  // Error counters and uncorrectable-error log; clear beats increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sb_cnt_q  <= '0;
      db_cnt_q  <= '0;
      db_err_q  <= 1'b0;
      db_addr_q <= '0;
    end else begin
      db_err_q <= (state_q == SRD) && dec.db;
      if ((state_q == SRD) && dec.db) db_addr_q <= scrub_addr_q;
      if (cnt_clr_i) begin
        sb_cnt_q <= '0;
        db_cnt_q <= '0;
      end else begin
        if ((state_q == SRD) && dec.sb && (sb_cnt_q != 16'hFFFF)) sb_cnt_q <= sb_cnt_q + 16'd1;
        if ((state_q == SRD) && dec.db && (db_cnt_q != 16'hFFFF)) db_cnt_q <= db_cnt_q + 16'd1;
      end
    end
  end

  assign host_rvalid_o = rvalid_q;
  assign host_q_o      = host_q_q;
  assign host_sberr_o  = sberr_q;
  assign host_dberr_o  = dberr_q;
  assign sb_cnt_o      = sb_cnt_q;
  assign db_cnt_o      = db_cnt_q;
  assign db_err_o      = db_err_q;
  assign db_addr_o     = db_addr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural synchronous memory.
// Small memory (AW=3) and short scrub interval (4) keep scenarios brief.
module tb_ecc_scrub_ctrl;

  localparam int K  = 32;
  localparam int AW = 3;
  localparam int SI = 4;
  localparam int N  = 39;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [K-1:0]  host_d;
  logic          host_gnt, host_rvalid, host_sberr, host_dberr;
  logic [K-1:0]  host_q;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_d;
  logic [N-1:0]  mem_q;
  logic          scrub_en, cnt_clr, scrub_busy, db_err;
  logic [15:0]   sb_cnt, db_cnt;
  logic [AW-1:0] db_addr;

  logic [N-1:0]  mem [8];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [N-1:0]  pl_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.K(K), .AW(AW), .SCRUB_INTERVAL(SI)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_d_i(host_d),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_q_o(host_q),
    .host_sberr_o(host_sberr), .host_dberr_o(host_dberr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_d_o(mem_d),
    .mem_q_i(mem_q), .scrub_en_i(scrub_en), .cnt_clr_i(cnt_clr),
    .scrub_busy_o(scrub_busy), .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt),
    .db_err_o(db_err), .db_addr_o(db_addr)
  );

  // Single-port memory with one-cycle read latency plus a bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_req) begin
      if (mem_we) mem[mem_addr] <= mem_d;
      else        mem_q <= mem[mem_addr];
    end
  end

  // Reference SECDED encoder: per-check-bit group parity over Hamming positions.
  function automatic logic [N-1:0] model_enc(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic         p;
    int           k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < N; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      p = 1'b0;
      for (int pos = 1; pos < N; pos++) if (((pos >> b) & 1) == 1) p ^= cw[pos];
      cw[1 << b] = p;
    end
    cw[0] = ^cw[N-1:1];
    return cw;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [N-1:0] w);
    step();
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = w;
    step();
    pl_en   = 1'b0;
  endtask

  // Waits (bounded) for a scrub read strobe; returns at the negedge of that cycle.
  task automatic wait_scrub(output logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we) begin
        a  = mem_addr;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd5; host_d = '1;
    for (int i = 0; i < 8; i++) preload(AW'(i), model_enc(32'h1000_0000 + i));
    @(negedge clk);
    n_tests++; if ({mem_req, host_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_strobe: got %b want 00", {mem_req, host_gnt}); end
    n_tests++; if ({host_rvalid, host_sberr, host_dberr, db_err, scrub_busy} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", {host_rvalid, host_sberr, host_dberr, db_err, scrub_busy}); end
    n_tests++; if (host_q !== 32'h0) begin n_fail++; $display("FAIL rst_q: got %h want 0", host_q); end
    n_tests++; if ({sb_cnt, db_cnt} !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", {sb_cnt, db_cnt}); end
    n_tests++; if (db_addr !== 3'd0) begin n_fail++; $display("FAIL rst_db_addr: got %0d want 0", db_addr); end
    step();
    rst_n = 1'b1; host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_write_read();
    step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd5; host_d = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if ({host_gnt, mem_req, mem_we} !== 3'b111 || mem_addr !== 3'd5) begin n_fail++; $display("FAIL wr_strobe: got %b addr %0d want 111 addr 5", {host_gnt, mem_req, mem_we}, mem_addr); end
    n_tests++; if (mem_d !== model_enc(32'hDEADBEEF)) begin n_fail++; $display("FAIL wr_codeword: got %h want %h", mem_d, model_enc(32'hDEADBEEF)); end
    step();
    host_we = 1'b0;  // read at T
    @(negedge clk);
    n_tests++; if ({host_gnt, mem_req, mem_we, host_rvalid} !== 4'b1100) begin n_fail++; $display("FAIL rd_grant: got %b want 1100", {host_gnt, mem_req, mem_we, host_rvalid}); end
    step();          // T+1: host still requesting, must be held off
    @(negedge clk);
    n_tests++; if ({host_gnt, mem_req, host_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rd_hold: got %b want 000", {host_gnt, mem_req, host_rvalid}); end
    step();          // T+2: data returned, next read granted
    @(negedge clk);
    n_tests++; if ({host_rvalid, host_gnt, host_sberr, host_dberr} !== 4'b1100) begin n_fail++; $display("FAIL rd_valid: got %b want 1100", {host_rvalid, host_gnt, host_sberr, host_dberr}); end
    n_tests++; if (host_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", host_q); end
    step();
    host_req = 1'b0;
    @(negedge clk);
    n_tests++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: got %b want 0", host_rvalid); end
    step();
    @(negedge clk);
    n_tests++; if (host_rvalid !== 1'b1 || host_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_second: got %b %h want 1 deadbeef", host_rvalid, host_q); end
  endtask

  task automatic test_back_to_back();
    logic [K-1:0] wd [3];
    logic [AW-1:0] wa [3];
    wd[0] = 32'hA5A5_0001; wd[1] = 32'h0000_FFFF; wd[2] = 32'h8000_0001;
    wa[0] = 3'd1; wa[1] = 3'd2; wa[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      host_req = 1'b1; host_we = 1'b1; host_addr = wa[i]; host_d = wd[i];
      @(negedge clk);
      n_tests++; if ({host_gnt, mem_we} !== 2'b11) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b want 11", i, {host_gnt, mem_we}); end
    end
    step();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (mem[wa[i]] !== model_enc(wd[i])) begin n_fail++; $display("FAIL b2b_mem%0d: got %h want %h", i, mem[wa[i]], model_enc(wd[i])); end
    end
  endtask

  task automatic test_host_read_errors();
    logic [N-1:0] bad6, bad7;
    bad6 = model_enc(32'hCAFE_0006) ^ (39'd1 << 10);
    bad7 = model_enc(32'hBEEF_0007) ^ (39'd1 << 3) ^ (39'd1 << 20);
    preload(3'd6, bad6);
    preload(3'd7, bad7);
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd6;
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if ({host_rvalid, host_sberr, host_dberr} !== 3'b110 || host_q !== 32'hCAFE_0006) begin n_fail++; $display("FAIL hrd_sb: got %b %h want 110 cafe0006", {host_rvalid, host_sberr, host_dberr}, host_q); end
    step();
    host_req = 1'b1; host_addr = 3'd7;
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if ({host_rvalid, host_sberr, host_dberr} !== 3'b101) begin n_fail++; $display("FAIL hrd_db: got %b want 101", {host_rvalid, host_sberr, host_dberr}); end
    n_tests++; if (mem[6] !== bad6) begin n_fail++; $display("FAIL hrd_no_wb: got %h want %h", mem[6], bad6); end
  endtask

  task automatic test_scrub_repair();
    logic [AW-1:0] a;
    bit ok;
    preload(3'd0, model_enc(32'h12345678) ^ (39'd1 << 7));
    step();
    scrub_en = 1'b1;
    wait_scrub(a, ok);
    n_tests++; if (!ok || a !== 3'd0 || scrub_busy !== 1'b0) begin n_fail++; $display("FAIL rep_read: got ok=%0d addr=%0d busy=%b want 1 0 0", ok, a, scrub_busy); end
    step();
    scrub_en = 1'b0;  // dropping enable must not abort the sequence
    @(negedge clk);
    n_tests++; if ({scrub_busy, mem_req} !== 2'b10) begin n_fail++; $display("FAIL rep_srd: got %b want 10", {scrub_busy, mem_req}); end
    step();
    @(negedge clk);
    n_tests++; if ({mem_req, mem_we, scrub_busy} !== 3'b111 || mem_addr !== 3'd0) begin n_fail++; $display("FAIL rep_swb: got %b addr %0d want 111 addr 0", {mem_req, mem_we, scrub_busy}, mem_addr); end
    n_tests++; if (mem_d !== model_enc(32'h12345678)) begin n_fail++; $display("FAIL rep_data: got %h want %h", mem_d, model_enc(32'h12345678)); end
    n_tests++; if (sb_cnt !== 16'd1 || db_cnt !== 16'd0) begin n_fail++; $display("FAIL rep_cnt: got %0d/%0d want 1/0", sb_cnt, db_cnt); end
    step();
    @(negedge clk);
    n_tests++; if (scrub_busy !== 1'b0 || mem[0] !== model_enc(32'h12345678)) begin n_fail++; $display("FAIL rep_mem: got busy=%b %h want 0 %h", scrub_busy, mem[0], model_enc(32'h12345678)); end
  endtask

  task automatic test_double_error();
    logic [AW-1:0] a;
    logic [N-1:0]  bad3;
    bit ok;
    bad3 = model_enc(32'h0BAD_0003) ^ (39'd1 << 2) ^ (39'd1 << 30);
    preload(3'd1, model_enc(32'h1111_1111));
    preload(3'd2, model_enc(32'h2222_2222));
    preload(3'd3, bad3);
    step();
    scrub_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_scrub(a, ok);
      n_tests++; if (!ok || a !== AW'(j + 1)) begin n_fail++; $display("FAIL dbl_addr%0d: got ok=%0d addr=%0d want %0d", j, ok, a, j + 1); end
      step();
      if (j == 2) scrub_en = 1'b0;
      step();
      @(negedge clk);
      if (j < 2) begin
        n_tests++; if ({mem_req, db_err} !== 2'b00 || sb_cnt !== 16'd1) begin n_fail++; $display("FAIL dbl_clean%0d: got %b cnt %0d want 00 cnt 1", j, {mem_req, db_err}, sb_cnt); end
      end else begin
        n_tests++; if ({db_err, mem_req} !== 2'b10) begin n_fail++; $display("FAIL dbl_pulse: got %b want 10", {db_err, mem_req}); end
        n_tests++; if (db_addr !== 3'd3 || db_cnt !== 16'd1) begin n_fail++; $display("FAIL dbl_log: got addr %0d cnt %0d want 3 1", db_addr, db_cnt); end
      end
    end
    step();
    @(negedge clk);
    n_tests++; if ({db_err, scrub_busy} !== 2'b00 || mem[3] !== bad3) begin n_fail++; $display("FAIL dbl_after: got %b %h want 00 %h", {db_err, scrub_busy}, mem[3], bad3); end
  endtask

  task automatic test_priority();
    preload(3'd4, model_enc(32'h4444_4444));
    step();
    scrub_en = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd5; host_d = 32'hDEADBEEF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++; if ({host_gnt, mem_we, scrub_busy} !== 3'b110) begin n_fail++; $display("FAIL pri_hold%0d: got %b want 110", i, {host_gnt, mem_we, scrub_busy}); end
      step();
    end
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    n_tests++; if ({mem_req, mem_we, scrub_busy} !== 3'b100 || mem_addr !== 3'd4) begin n_fail++; $display("FAIL pri_issue: got %b addr %0d want 100 addr 4", {mem_req, mem_we, scrub_busy}, mem_addr); end
    step();
    scrub_en = 1'b0;
    host_req = 1'b1; host_addr = 3'd4;
    @(negedge clk);
    n_tests++; if ({host_gnt, scrub_busy} !== 2'b01) begin n_fail++; $display("FAIL pri_blocked: got %b want 01", {host_gnt, scrub_busy}); end
    step();
    @(negedge clk);
    n_tests++; if ({host_gnt, scrub_busy} !== 2'b10) begin n_fail++; $display("FAIL pri_resume: got %b want 10", {host_gnt, scrub_busy}); end
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if (host_rvalid !== 1'b1 || host_q !== 32'h4444_4444) begin n_fail++; $display("FAIL pri_read: got %b %h want 1 44444444", host_rvalid, host_q); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    bit ok;
    step();
    scrub_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_scrub(a, ok);
      n_tests++; if (!ok || a !== AW'(5 + j)) begin n_fail++; $display("FAIL wrap_addr%0d: got ok=%0d addr=%0d want %0d", j, ok, a, (5 + j) % 8); end
    end
    step();
    scrub_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    n_tests++; if (sb_cnt !== 16'd2 || db_cnt !== 16'd2 || db_addr !== 3'd7) begin n_fail++; $display("FAIL wrap_cnt: got %0d/%0d addr %0d want 2/2 addr 7", sb_cnt, db_cnt, db_addr); end
    n_tests++; if (mem[6] !== model_enc(32'hCAFE_0006)) begin n_fail++; $display("FAIL wrap_repair: got %h want %h", mem[6], model_enc(32'hCAFE_0006)); end
  endtask

  task automatic test_saturation();
    logic [AW-1:0] a;
    bit ok;
    step();
    force dut.sb_cnt_q = 16'hFFFF;
    step();
    release dut.sb_cnt_q;
    preload(3'd1, model_enc(32'h5A5A_0001) ^ (39'd1 << 38));
    @(negedge clk);
    n_tests++; if (sb_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preset: got %h want ffff", sb_cnt); end
    step();
    scrub_en = 1'b1;
    wait_scrub(a, ok);
    n_tests++; if (!ok || a !== 3'd1) begin n_fail++; $display("FAIL sat_addr: got ok=%0d addr=%0d want 1", ok, a); end
    step();
    scrub_en = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if (sb_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", sb_cnt); end
    n_tests++; if (mem_we !== 1'b1 || mem_d !== model_enc(32'h5A5A_0001)) begin n_fail++; $display("FAIL sat_wb: got %b %h want 1 %h", mem_we, mem_d, model_enc(32'h5A5A_0001)); end
  endtask

  task automatic test_clear();
    logic [AW-1:0] a;
    bit ok;
    preload(3'd2, model_enc(32'h2222_2222) ^ (39'd1 << 15));
    step();
    scrub_en = 1'b1;
    wait_scrub(a, ok);
    n_tests++; if (!ok || a !== 3'd2) begin n_fail++; $display("FAIL clr_addr: got ok=%0d addr=%0d want 2", ok, a); end
    step();
    scrub_en = 1'b0;
    cnt_clr  = 1'b1;  // same cycle as the increment decision
    step();
    cnt_clr  = 1'b0;
    @(negedge clk);
    n_tests++; if (sb_cnt !== 16'd0 || db_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", sb_cnt, db_cnt); end
    n_tests++; if (mem_we !== 1'b1 || mem_addr !== 3'd2) begin n_fail++; $display("FAIL clr_wb: got %b addr %0d want 1 addr 2", mem_we, mem_addr); end
  endtask

  task automatic test_reset_mid_scrub();
    logic [AW-1:0] a;
    logic [N-1:0]  bad;
    bit ok;
    bad = model_enc(32'h3333_0003) ^ (39'd1 << 5);
    preload(3'd3, bad);
    step();
    scrub_en = 1'b1;
    wait_scrub(a, ok);
    n_tests++; if (!ok || a !== 3'd3) begin n_fail++; $display("FAIL rms_addr: got ok=%0d addr=%0d want 3", ok, a); end
    step();
    scrub_en = 1'b0;
    step();
    rst_n = 1'b0;  // during SWB
    @(negedge clk);
    n_tests++; if ({mem_req, mem_we} !== 2'b00) begin n_fail++; $display("FAIL rms_strobe: got %b want 00", {mem_req, mem_we}); end
    step();
    rst_n = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd3;
    @(negedge clk);
    n_tests++; if ({host_gnt, scrub_busy, host_rvalid, db_err} !== 4'b1000) begin n_fail++; $display("FAIL rms_idle: got %b want 1000", {host_gnt, scrub_busy, host_rvalid, db_err}); end
    n_tests++; if ({sb_cnt, db_cnt} !== 32'h0 || db_addr !== 3'd0 || host_q !== 32'h0) begin n_fail++; $display("FAIL rms_regs: got %h %0d %h want 0 0 0", {sb_cnt, db_cnt}, db_addr, host_q); end
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if ({host_rvalid, host_sberr} !== 2'b11 || host_q !== 32'h3333_0003) begin n_fail++; $display("FAIL rms_read: got %b %h want 11 33330003", {host_rvalid, host_sberr}, host_q); end
    n_tests++; if (mem[3] !== bad) begin n_fail++; $display("FAIL rms_no_wb: got %h want %h", mem[3], bad); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_host_read_errors();
    test_scrub_repair();
    test_double_error();
    test_priority();
    test_wrap();
    test_saturation();
    test_clear();
    test_reset_mid_scrub();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
